// File: rtl/ippcrc_pkg.sv
// Shared CRC-32 constants, FSM state type, debug view and byte-step helpers
// for the 120-bit word CRC engine.
package ippcrc_pkg;

   localparam logic [31:0] CRC_POLY    = 32'h04C11DB7;
   localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;
   localparam int          WORD_BYTES  = 15;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      TAIL = 2'd2
   } state_e;

   typedef struct packed {
      state_e      state;
      logic [31:0] crc;
      logic [3:0]  tail_cnt;
   } dbg_t;

   // MSB-first, non-reflected: data bit 7 enters the shift register first.
   function automatic logic [31:0] crc32_step8(input logic [31:0] crc, input logic [7:0] data);
      logic [31:0] c;
      c = crc;
      for (int i = 7; i >= 0; i--) begin
         if (c[31] ^ data[i]) c = {c[30:0], 1'b0} ^ CRC_POLY;
         else                 c = {c[30:0], 1'b0};
      end
      return c;
   endfunction

   // A bus lane carries byte bit 7 in its lowest bit position.
   function automatic logic [7:0] lane_byte(input logic [7:0] lane);
      logic [7:0] b;
      b = '0;
      for (int i = 0; i < 8; i++) b[7-i] = lane[i];
      return b;
   endfunction

endpackage

// File: rtl/ippcrc_crc32_eng_if.sv
// Word stream into the CRC engine and the CRC result back out.
interface ippcrc_crc32_eng_if;

   // A word transfers on a rising edge where i_vld & o_rdy; i_sop/i_eop/i_nbyte/i_dat
   // are only meaningful while i_vld is high. Results are a one-cycle o_crc_vld pulse
   // with o_crc/o_crc_ok held until the next pulse; there is no back-pressure on them.
   logic         i_vld;
   logic         i_sop;
   logic         i_eop;
   logic [3:0]   i_nbyte;
   logic [119:0] i_dat;
   logic         o_rdy;
   logic         o_crc_vld;
   logic [31:0]  o_crc;
   logic         o_crc_ok;

   modport master (
      output i_vld, i_sop, i_eop, i_nbyte, i_dat,
      input  o_rdy, o_crc_vld, o_crc, o_crc_ok
   );

   modport slave (
      input  i_vld, i_sop, i_eop, i_nbyte, i_dat,
      output o_rdy, o_crc_vld, o_crc, o_crc_ok
   );

endinterface

// File: rtl/ippcrc_crc32_120b.sv
// Combinational CRC-32 update over a full 15-byte word, byte 0 first.
module ippcrc_crc32_120b
   import ippcrc_pkg::*;
(
   input  logic [31:0]  ci,
   input  logic [119:0] di,
   output logic [31:0]  co
);

   always_comb begin
      co = ci;
      for (int k = 0; k < WORD_BYTES; k++) begin
         co = crc32_step8(co, lane_byte(di[8*k +: 8]));
      end
   end

endmodule

// File: rtl/ippcrc_crc32_eng.sv
// Packet CRC-32 engine: full words update in one cycle, a short last word is
// finished one byte per cycle while input is held off.
module ippcrc_crc32_eng
   import ippcrc_pkg::*;
#(
   parameter logic [31:0] CRC_INIT   = 32'hFFFFFFFF,
   parameter logic [31:0] CRC_XOROUT = 32'hFFFFFFFF
) (
   input  logic               clk,
   input  logic               rst_,
   ippcrc_crc32_eng_if.slave  bus,
   output dbg_t               dbg
);

   state_e       state_q, state_n;
   logic [31:0]  crc_q, crc_n;
   logic [119:0] tail_q, tail_n;
   logic [3:0]   cnt_q, cnt_n;
   logic [31:0]  base, word_crc, tail_crc;
   logic [3:0]   n_eff;
   logic         accept;
   logic         done;
   logic         crc_vld_q;
   logic [31:0]  crc_out_q;
   logic         crc_ok_q;

   assign bus.o_rdy = (state_q != TAIL);
   assign accept    = bus.i_vld & bus.o_rdy;
   assign n_eff     = (bus.i_nbyte == 4'd0) ? 4'd15 : bus.i_nbyte;
   assign base      = bus.i_sop ? CRC_INIT : crc_q;
   assign tail_crc  = crc32_step8(crc_q, lane_byte(tail_q[7:0]));

   ippcrc_crc32_120b u_word (
      .ci (base),
      .di (bus.i_dat),
      .co (word_crc)
   );

   always_comb begin
      state_n = state_q;
      crc_n   = crc_q;
      tail_n  = tail_q;
      cnt_n   = cnt_q;
      done    = 1'b0;
      case (state_q)
         IDLE, RUN: begin
            // Words without sop are dropped in IDLE; sop in RUN restarts the packet.
            if (accept && (bus.i_sop || state_q == RUN)) begin
               if (!bus.i_eop) begin
                  crc_n   = word_crc;
                  state_n = RUN;
               end else if (n_eff == 4'd15) begin
                  crc_n   = word_crc;
                  done    = 1'b1;
                  state_n = IDLE;
               end else begin
                  crc_n   = base;
                  tail_n  = bus.i_dat;
                  cnt_n   = n_eff;
                  state_n = TAIL;
               end
            end
         end
         TAIL: begin
            crc_n  = tail_crc;
            tail_n = {8'h00, tail_q[119:8]};
            cnt_n  = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               done    = 1'b1;
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_) begin
         state_q   <= IDLE;
         crc_q     <= CRC_INIT;
         tail_q    <= '0;
         cnt_q     <= '0;
         crc_vld_q <= 1'b0;
         crc_out_q <= '0;
         crc_ok_q  <= 1'b0;
      end else begin
         state_q   <= state_n;
         crc_q     <= crc_n;
         tail_q    <= tail_n;
         cnt_q     <= cnt_n;
         crc_vld_q <= done;
         if (done) begin
            crc_out_q <= crc_n ^ CRC_XOROUT;
            crc_ok_q  <= (crc_n == CRC_RESIDUE);
         end
      end
   end

   assign bus.o_crc_vld = crc_vld_q;
   assign bus.o_crc     = crc_out_q;
   assign bus.o_crc_ok  = crc_ok_q;
   assign dbg           = '{state: state_q, crc: crc_q, tail_cnt: cnt_q};

endmodule

// File: tb/tb_ippcrc_crc32_eng.sv
// Bench for ippcrc_crc32_eng: driver tasks, bit-serial reference model and an
// expected-result queue popped on every o_crc_vld pulse.
module tb_ippcrc_crc32_eng;
   import ippcrc_pkg::*;

   localparam logic [31:0] INIT = 32'hFFFFFFFF;
   localparam logic [31:0] XORO = 32'hFFFFFFFF;
   localparam logic [31:0] RES  = 32'hC704DD7B;

   logic clk;
   logic rst_;
   dbg_t dbg;
   ippcrc_crc32_eng_if bus ();

   ippcrc_crc32_eng #(.CRC_INIT(INIT), .CRC_XOROUT(XORO)) dut (
      .clk  (clk),
      .rst_ (rst_),
      .bus  (bus),
      .dbg  (dbg)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int  checks   = 0;
   int  failures = 0;
   time t_eop    = 0;

   // expected item: {latency[7:0], crc_ok, crc[31:0]}
   logic [40:0] exp_q[$];

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      if (obs !== expv) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
      end
   endtask

   // ---------------- model ----------------
   function automatic logic [31:0] model_upd(input logic [31:0] c, input logic [119:0] w, input int nb);
      logic [31:0] r;
      r = c;
      for (int i = 0; i < 8*nb; i++) begin
         r = {r[30:0], 1'b0} ^ ((r[31] ^ w[i]) ? 32'h04C11DB7 : 32'h0);
      end
      return r;
   endfunction

   function automatic logic [7:0] rev8(input logic [7:0] b);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[i] = b[7-i];
      return r;
   endfunction

   function automatic logic [119:0] rand_word();
      logic [119:0] w;
      for (int k = 0; k < 15; k++) w[8*k +: 8] = 8'($urandom_range(0, 255));
      return w;
   endfunction

   task automatic push_exp(input logic [31:0] reg_v, input int lat);
      exp_q.push_back({8'(lat), reg_v == RES, reg_v ^ XORO});
   endtask

   // ---------------- driver tasks ----------------
   task automatic send(input logic sop, input logic eop, input logic [3:0] nb, input logic [119:0] dat);
      int n;
      n = 0;
      @(negedge clk);
      while (!bus.o_rdy && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) check_eq("rdy_timeout", 0, 1);
      bus.i_vld   = 1'b1;
      bus.i_sop   = sop;
      bus.i_eop   = eop;
      bus.i_nbyte = nb;
      bus.i_dat   = dat;
      if (eop) t_eop = $time;
      @(posedge clk);
      #1 bus.i_vld = 1'b0;
   endtask

   // Idle cycles with junk on the qualified inputs.
   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         bus.i_sop   = 1'($urandom_range(0, 1));
         bus.i_eop   = 1'($urandom_range(0, 1));
         bus.i_nbyte = 4'($urandom_range(0, 15));
         bus.i_dat   = rand_word();
      end
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check_eq("drain", exp_q.size(), 0);
      exp_q.delete();
   endtask

   // ---------------- scoreboard ----------------
   logic [40:0] item;
   int          lat;

   always @(negedge clk) begin
      if (bus.o_crc_vld) begin
         if (exp_q.size() == 0) begin
            check_eq("unexpected_vld", 1, 0);
         end else begin
            item = exp_q.pop_front();
            lat  = int'(($time - t_eop) / 10);
            check_eq("crc", bus.o_crc, item[31:0]);
            check_eq("crc_ok", bus.o_crc_ok, item[32]);
            check_eq("latency", lat, item[40:33]);
         end
      end
   end

   // ---------------- stimulus ----------------
   logic [7:0]   msg[13] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37,
                             8'h38, 8'h39, 8'hFC, 8'h89, 8'h19, 8'h18};
   logic [119:0] w0, w1, w2, wm;
   logic [31:0]  r;
   int           low;

   initial begin
      rst_        = 1'b0;
      bus.i_vld   = 1'b0;
      bus.i_sop   = 1'b0;
      bus.i_eop   = 1'b0;
      bus.i_nbyte = 4'd0;
      bus.i_dat   = '0;
      repeat (3) @(posedge clk);
      #1 rst_ = 1'b1;
      @(negedge clk);
      check_eq("rst_rdy", bus.o_rdy, 1);
      check_eq("rst_vld", bus.o_crc_vld, 0);
      check_eq("rst_crc", bus.o_crc, 0);
      check_eq("rst_ok", bus.o_crc_ok, 0);
      check_eq("rst_state", dbg.state, IDLE);
      check_eq("rst_reg", dbg.crc, INIT);

      // "123456789" as one short sop+eop word, junk in the unused lanes
      wm = rand_word();
      for (int k = 0; k < 9; k++) wm[8*k +: 8] = rev8(msg[k]);
      exp_q.push_back({8'd10, 1'b0, 32'hFC891918});
      send(1'b1, 1'b1, 4'd9, wm);
      low = 0;
      repeat (15) begin
         @(negedge clk);
         if (!bus.o_rdy) low++;
      end
      check_eq("rdy_low_cycles", low, 9);
      wait_drain();

      // message plus its CRC gives the residue
      wm = rand_word();
      for (int k = 0; k < 13; k++) wm[8*k +: 8] = rev8(msg[k]);
      exp_q.push_back({8'd14, 1'b1, 32'h38FB2284});
      send(1'b1, 1'b1, 4'd13, wm);
      wait_drain();
      idle(3);
      check_eq("residue_reg", dbg.crc, RES);
      check_eq("crc_held", bus.o_crc, 32'h38FB2284);
      check_eq("ok_held", bus.o_crc_ok, 1);

      wm[19] = ~wm[19];
      r = model_upd(INIT, wm, 13);
      push_exp(r, 14);
      send(1'b1, 1'b1, 4'd13, wm);
      wait_drain();

      // two full words + 5-byte tail with gaps
      w0 = rand_word();
      w1 = rand_word();
      w2 = rand_word();
      r  = model_upd(model_upd(model_upd(INIT, w0, 15), w1, 15), w2, 5);
      send(1'b1, 1'b0, 4'($urandom_range(0, 15)), w0);
      idle($urandom_range(1, 3));
      send(1'b0, 1'b0, 4'($urandom_range(0, 15)), w1);
      idle($urandom_range(1, 3));
      push_exp(r, 6);
      send(1'b0, 1'b1, 4'd5, w2);
      wait_drain();

      // full eop word: nbyte 15 and nbyte 0 behave the same
      w0 = rand_word();
      r  = model_upd(INIT, w0, 15);
      push_exp(r, 1);
      send(1'b1, 1'b1, 4'd15, w0);
      wait_drain();
      push_exp(r, 1);
      send(1'b1, 1'b1, 4'd0, w0);
      wait_drain();

      // word without sop in IDLE is dropped
      send(1'b0, 1'b0, 4'd3, rand_word());
      @(negedge clk);
      check_eq("drop_state", dbg.state, IDLE);
      check_eq("drop_reg", dbg.crc, r);

      // sop during RUN restarts the packet
      w0 = rand_word();
      w1 = rand_word();
      w2 = rand_word();
      r  = model_upd(model_upd(INIT, w1, 15), w2, 7);
      send(1'b1, 1'b0, 4'd0, w0);
      idle(1);
      send(1'b1, 1'b0, 4'd0, w1);
      push_exp(r, 8);
      send(1'b0, 1'b1, 4'd7, w2);
      wait_drain();

      // reset on the third TAIL cycle
      send(1'b1, 1'b1, 4'd12, rand_word());
      @(posedge clk);
      @(posedge clk);
      #1 rst_ = 1'b0;
      @(negedge clk);
      check_eq("pre_rst_state", dbg.state, TAIL);
      @(posedge clk);
      #1 rst_ = 1'b1;
      @(negedge clk);
      check_eq("tail_rst_rdy", bus.o_rdy, 1);
      check_eq("tail_rst_vld", bus.o_crc_vld, 0);
      check_eq("tail_rst_crc", bus.o_crc, 0);
      check_eq("tail_rst_reg", dbg.crc, INIT);
      idle(20);

      wm = rand_word();
      for (int k = 0; k < 9; k++) wm[8*k +: 8] = rev8(msg[k]);
      exp_q.push_back({8'd10, 1'b0, 32'hFC891918});
      send(1'b1, 1'b1, 4'd9, wm);
      wait_drain();
      idle(4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
